spike_core_mc: RTL and testbench
================================

Name: spike_core_mc

Overview:
- Parametrised successor of the TTFS spike-time core.
- Holds one spike-time entry per neuron in a packed word-addressed SRAM. Entries are written by a CPU slave port and by neuron-output pushback.
- On a start pulse, a scan FSM emits into an output FIFO the index of every neuron whose stored time equals the current tick.
- Generalised over neuron count, time width, FIFO depth and an optional clear-on-emit mode. Adds a pushback ready handshake, registered SRAM reads, FIFO occupancy output and stall-safe arbitration.

Parameters:
N, 256, neuron count; power of two, at least 32/TW.
TW, 8, spike-time width in bits; 8 or 16. LANES = 32/TW entries per 32-bit word.
DEPTH, 128, output FIFO depth; power of two.
CLEAR_ON_EMIT, 0, when 1 the scanner writes 0 to each lane it emits.
AW, $clog2(N*TW/32), word address width (derived).

Ports:
CLK  in  1  clock.
RSTN  in  1  asynchronous active-low reset.
bus_req_i  in  1  CPU slave request.
bus_we_i  in  1  write enable.
bus_be_i  in  4  byte enables.
bus_addr_i  in  32  byte address; word index = addr[AW+1:2].
bus_wdata_i  in  32  write data.
bus_gnt_o  out  1  grant.
bus_rvalid_o  out  1  response valid.
bus_rdata_o  out  32  read data.
start_i  in  1  scan start pulse.
tick_i  in  TW  current time tick.
busy_o  out  1  scan in progress.
done_o  out  1  one-cycle scan-complete pulse.
pb_valid_i  in  1  pushback spike valid.
pb_addr_i  in  $clog2(N)  spiking neuron index.
pb_ready_o  out  1  pushback accepted.
fifo_rd_i  in  1  FIFO pop.
fifo_data_o  out  $clog2(N)  FIFO head (show-ahead).
fifo_empty_o  out  1  FIFO empty.
fifo_count_o  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset values: all outputs 0 except fifo_empty_o=1. FSM goes to IDLE and the FIFO pointers clear. SRAM contents are not reset. Reset mid-scan aborts the scan with no done_o pulse.
- SRAM: single port, byte write enables, synchronous read with data valid the cycle after the read enable. Stored time 0 means "no spike".
- Arbitration, one access per cycle, priority bus > pushback > scanner.
- Bus: bus_gnt_o = bus_req_i, combinational.
- Bus: bus_rvalid_o is registered, high the cycle after every grant, reads and writes alike.
- Bus: bus_rdata_o is the SRAM word on read; on write it is don't-care and the bench drives it 0.
- Pushback: pb_ready_o = pb_valid_i & ~bus_req_i. A transfer happens on valid & ready.
- Pushback write: word pb_addr_i/LANES, lane pb_addr_i%LANES, lane-only byte enables.
- Pushback value: tick_i+1, saturating at 2^TW-1; it never wraps to 0.
- Scanner FSM:
  - IDLE: start_i & ~busy_o goes to RD. start_i while busy is ignored.
  - RD: issue a read of word w (starting at w=0) when no higher-priority access is present, otherwise retry next cycle; go to CAP.
  - CAP: latch the returned word into a local buffer; lane=0; go to EMIT.
  - EMIT: one lane per cycle.
    - Match if entry==tick_i and entry!=0.
    - On a match with FIFO not full: push index w*LANES+lane. If CLEAR_ON_EMIT, queue a lane-zero write, issued in the first cycle the port is free and before the next RD.
    - On a match with FIFO full: stall on that lane.
    - Non-matching lanes take one cycle each.
    - After the last lane: if w = last word go to DONE, else w++ and go to RD.
  - DONE: done_o=1 for one cycle, then IDLE.
  - busy_o=1 in every state except IDLE.
- Coherence: the scanner compares against its captured buffer. A pushback to the word being emitted does not affect the current scan.
- tick_i must stay stable while busy_o=1.
- FIFO:
  - A push when full never occurs, because the scanner stalls.
  - A pop when empty is ignored.
  - Simultaneous push and pop keeps the count unchanged.
  - fifo_data_o is valid whenever fifo_empty_o=0.
  - Pointers wrap modulo DEPTH.

Test Plan:
- Bus write 0x0403_0201 to word 0, then read word 0 -> rvalid the cycle after each gnt; rdata=0x04030201.
- TW=8, entries n5=3, n6=3, n200=3, all others 0, tick_i=3, start -> FIFO pops 5, 6, 200 in order; done_o pulses once; busy_o is 0 afterwards.
- Pushback n9 with tick_i=7 while bus_req_i=1 -> pb_ready_o=0 until the bus drops; then byte 1 of word 2 is 8. With tick_i=255 the stored value is 255.
- Bus requests every other cycle during a scan -> the scanner retries RD; the emitted set is unchanged; no lost or duplicated index.
- DEPTH=4, 6 matching neurons, no pops -> count saturates at 4 and the scanner stalls. After 2 pops the remaining 2 appear; done_o follows the final emit.
- CLEAR_ON_EMIT=1: scan with a match on n5, then rescan with the same tick -> second scan emits nothing. RSTN low mid-scan -> FIFO empty, no done_o, SRAM retains its data.

Source files
------------

// File: rtl/spike_core_mc.sv
// TTFS spike-time core: word-packed spike-time SRAM shared by a CPU port, neuron pushback
// and a scanner that queues the index of every neuron whose stored time equals the tick.
module spike_core_mc #(
    parameter int N             = 256,
    parameter int TW            = 8,
    parameter int DEPTH         = 128,
    parameter bit CLEAR_ON_EMIT = 1'b0,
    parameter int AW            = $clog2(N*TW/32)
) (
    input  logic                     CLK,
    input  logic                     RSTN,
    input  logic                     bus_req_i,
    input  logic                     bus_we_i,
    input  logic [3:0]               bus_be_i,
    input  logic [31:0]              bus_addr_i,
    input  logic [31:0]              bus_wdata_i,
    output logic                     bus_gnt_o,
    output logic                     bus_rvalid_o,
    output logic [31:0]              bus_rdata_o,
    input  logic                     start_i,
    input  logic [TW-1:0]            tick_i,
    output logic                     busy_o,
    output logic                     done_o,
    input  logic                     pb_valid_i,
    input  logic [$clog2(N)-1:0]     pb_addr_i,
    output logic                     pb_ready_o,
    input  logic                     fifo_rd_i,
    output logic [$clog2(N)-1:0]     fifo_data_o,
    output logic                     fifo_empty_o,
    output logic [$clog2(DEPTH):0]   fifo_count_o
);
    localparam int LANES = 32 / TW;
    localparam int NW    = N / LANES;
    localparam int LW    = $clog2(LANES);
    localparam int IW    = $clog2(N);
    localparam int PW    = $clog2(DEPTH);
    localparam int BPL   = TW / 8;
    localparam logic [TW-1:0] TMAX = '1;

    typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_EMIT, S_DONE} state_t;

    function automatic logic [3:0] lane_be(input logic [LANES-1:0] mask);
        logic [3:0] be;
        for (int b = 0; b < 4; b++) be[b] = mask[b / BPL];
        return be;
    endfunction

    logic [31:0]      r_mem [NW];
    logic [31:0]      r_q;
    logic [31:0]      r_buf;
    logic             r_rvalid;
    logic             r_rd_resp;
    state_t           r_state;
    logic             r_busy;
    logic             r_done;
    logic [AW-1:0]    r_word;
    logic [LW-1:0]    r_lane;
    logic [LANES-1:0] r_clr_mask;
    logic [AW-1:0]    r_clr_word;
    logic [IW-1:0]    r_fifo [DEPTH];
    logic [PW-1:0]    r_wp;
    logic [PW-1:0]    r_rp;
    logic [PW:0]      r_cnt;

    logic             w_pb_go;
    logic             w_port_free;
    logic             w_clr_go;
    logic             w_rd_go;
    logic [TW-1:0]    w_pb_val;
    logic             w_en;
    logic             w_we;
    logic [3:0]       w_be;
    logic [AW-1:0]    w_addr;
    logic [31:0]      w_wdata;
    logic [TW-1:0]    w_entry;
    logic             w_match;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic             w_unused;

    assign w_unused    = ^{bus_addr_i[31:AW+2], bus_addr_i[1:0]};
    assign w_pb_go     = pb_valid_i & ~bus_req_i;
    assign w_port_free = ~bus_req_i & ~w_pb_go;
    // Pending clears drain before the next word read so a rescan never sees stale lanes.
    assign w_clr_go    = w_port_free & (|r_clr_mask);
    assign w_rd_go     = w_port_free & ~(|r_clr_mask) & (r_state == S_RD);
    assign w_pb_val    = (tick_i == TMAX) ? TMAX : tick_i + TW'(1);

    always_comb begin
        w_en    = 1'b0;
        w_we    = 1'b0;
        w_be    = 4'h0;
        w_addr  = '0;
        w_wdata = '0;
        if (bus_req_i) begin
            w_en    = 1'b1;
            w_we    = bus_we_i;
            w_be    = bus_be_i;
            w_addr  = bus_addr_i[AW+1:2];
            w_wdata = bus_wdata_i;
        end else if (w_pb_go) begin
            w_en    = 1'b1;
            w_we    = 1'b1;
            w_be    = lane_be(LANES'(1) << pb_addr_i[LW-1:0]);
            w_addr  = pb_addr_i[IW-1:LW];
            w_wdata = {LANES{w_pb_val}};
        end else if (w_clr_go) begin
            w_en    = 1'b1;
            w_we    = 1'b1;
            w_be    = lane_be(r_clr_mask);
            w_addr  = r_clr_word;
        end else if (w_rd_go) begin
            w_en    = 1'b1;
            w_addr  = r_word;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_en && w_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) r_mem[w_addr][8*b +: 8] <= w_wdata[8*b +: 8];
            end
        end
        if (w_en && !w_we) r_q <= r_mem[w_addr];
        if (r_state == S_CAP) r_buf <= r_q;
        if (w_push) r_fifo[r_wp] <= {r_word, r_lane};
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_rvalid  <= 1'b0;
            r_rd_resp <= 1'b0;
        end else begin
            r_rvalid  <= bus_req_i;
            r_rd_resp <= bus_req_i & ~bus_we_i;
        end
    end

    // r_q is shared with the scanner, so only expose it on a bus read response.
    assign bus_gnt_o    = bus_req_i;
    assign bus_rvalid_o = r_rvalid;
    assign bus_rdata_o  = r_rd_resp ? r_q : 32'h0;
    assign pb_ready_o   = w_pb_go;

    assign w_entry = r_buf[r_lane*TW +: TW];
    assign w_match = (r_state == S_EMIT) && (w_entry == tick_i) && (w_entry != '0);
    assign w_full  = (r_cnt == (PW+1)'(DEPTH));
    assign w_push  = w_match & ~w_full;
    assign w_pop   = fifo_rd_i & (r_cnt != '0);

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_word     <= '0;
            r_lane     <= '0;
            r_clr_mask <= '0;
            r_clr_word <= '0;
        end else begin
            r_clr_mask <= (w_clr_go ? '0 : r_clr_mask) |
                          ((CLEAR_ON_EMIT && w_push) ? (LANES'(1) << r_lane) : '0);
            if (CLEAR_ON_EMIT && w_push) r_clr_word <= r_word;
            case (r_state)
                S_IDLE: begin
                    if (start_i && !r_busy) begin
                        r_state <= S_RD;
                        r_busy  <= 1'b1;
                        r_word  <= '0;
                    end
                end
                S_RD: begin
                    if (w_rd_go) r_state <= S_CAP;
                end
                S_CAP: begin
                    r_lane  <= '0;
                    r_state <= S_EMIT;
                end
                S_EMIT: begin
                    // A match against a full FIFO holds the lane until a pop frees a slot.
                    if (!(w_match && w_full)) begin
                        if (r_lane == LW'(LANES-1)) begin
                            r_lane <= '0;
                            if (r_word == AW'(NW-1)) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_word  <= r_word + AW'(1);
                                r_state <= S_RD;
                            end
                        end else begin
                            r_lane <= r_lane + LW'(1);
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o = r_busy;
    assign done_o = r_done;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + PW'(1);
            if (w_pop)  r_rp <= r_rp + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + (PW+1)'(1);
                2'b01:   r_cnt <= r_cnt - (PW+1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign fifo_empty_o = (r_cnt == '0);
    assign fifo_count_o = r_cnt;
    assign fifo_data_o  = (r_cnt == '0) ? '0 : r_fifo[r_rp];

endmodule

// File: tb/tb_spike_core_mc.sv
// Directed bench for spike_core_mc (N=256, TW=8, DEPTH=4, clear-on-emit) with scoreboard queues.
module tb_spike_core_mc;
    logic        CLK;
    logic        RSTN;
    logic        bus_req_i;
    logic        bus_we_i;
    logic [3:0]  bus_be_i;
    logic [31:0] bus_addr_i;
    logic [31:0] bus_wdata_i;
    logic        bus_gnt_o;
    logic        bus_rvalid_o;
    logic [31:0] bus_rdata_o;
    logic        start_i;
    logic [7:0]  tick_i;
    logic        busy_o;
    logic        done_o;
    logic        pb_valid_i;
    logic [7:0]  pb_addr_i;
    logic        pb_ready_o;
    logic        fifo_rd_i;
    logic [7:0]  fifo_data_o;
    logic        fifo_empty_o;
    logic [2:0]  fifo_count_o;

    int ncomp = 0;
    int nfail = 0;
    logic [31:0] q_idx [$];
    logic [31:0] q_rd  [$];

    spike_core_mc #(.N(256), .TW(8), .DEPTH(4), .CLEAR_ON_EMIT(1'b1)) dut (
        .CLK(CLK), .RSTN(RSTN),
        .bus_req_i(bus_req_i), .bus_we_i(bus_we_i), .bus_be_i(bus_be_i),
        .bus_addr_i(bus_addr_i), .bus_wdata_i(bus_wdata_i),
        .bus_gnt_o(bus_gnt_o), .bus_rvalid_o(bus_rvalid_o), .bus_rdata_o(bus_rdata_o),
        .start_i(start_i), .tick_i(tick_i), .busy_o(busy_o), .done_o(done_o),
        .pb_valid_i(pb_valid_i), .pb_addr_i(pb_addr_i), .pb_ready_o(pb_ready_o),
        .fifo_rd_i(fifo_rd_i), .fifo_data_o(fifo_data_o),
        .fifo_empty_o(fifo_empty_o), .fifo_count_o(fifo_count_o)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncomp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_wr(input int word, input logic [31:0] data);
        @(posedge CLK); #1;
        bus_req_i = 1'b1; bus_we_i = 1'b1; bus_be_i = 4'hF;
        bus_addr_i = word * 4; bus_wdata_i = data;
        #1 check("gnt_wr", bus_gnt_o, 1);
        @(posedge CLK); #1;
        bus_req_i = 1'b0; bus_we_i = 1'b0;
        check("rvalid_wr", bus_rvalid_o, 1);
    endtask

    task automatic bus_rd(input string tag, input int word, input logic [31:0] exp);
        logic [31:0] e;
        q_rd.push_back(exp);
        @(posedge CLK); #1;
        bus_req_i = 1'b1; bus_we_i = 1'b0; bus_be_i = 4'hF; bus_addr_i = word * 4;
        #1 check("gnt_rd", bus_gnt_o, 1);
        @(posedge CLK); #1;
        bus_req_i = 1'b0;
        check("rvalid_rd", bus_rvalid_o, 1);
        e = (q_rd.size() > 0) ? q_rd.pop_front() : 32'hDEAD_BEEF;
        check(tag, bus_rdata_o, e);
    endtask

    task automatic pop_chk();
        logic [31:0] e;
        @(posedge CLK); #1;
        e = (q_idx.size() > 0) ? q_idx.pop_front() : 32'hFFFF_FFFF;
        check("fifo_not_empty", fifo_empty_o, 0);
        check("fifo_idx", {24'h0, fifo_data_o}, e);
        fifo_rd_i = 1'b1;
        @(posedge CLK); #1;
        fifo_rd_i = 1'b0;
    endtask

    task automatic pulse_start(input logic [7:0] tick);
        @(posedge CLK); #1;
        tick_i = tick; start_i = 1'b1;
        @(posedge CLK); #1;
        start_i = 1'b0;
    endtask

    // Runs until busy drops (bounded), optionally toggling bus reads every cycle.
    task automatic wait_scan(input int maxcyc, input bit toggle, output int ndone);
        bit fin;
        fin = 1'b0;
        ndone = 0;
        for (int c = 0; c < maxcyc && !fin; c++) begin
            if (done_o) ndone++;
            if (!busy_o) fin = 1'b1;
            else begin
                if (toggle) begin
                    bus_req_i = ~bus_req_i; bus_we_i = 1'b0; bus_addr_i = 32'hFC;
                end
                @(posedge CLK); #1;
            end
        end
        bus_req_i = 1'b0;
        check("scan_finished", fin, 1);
    endtask

    initial begin
        int nd;
        int cyc;
        RSTN = 1'b0; bus_req_i = 1'b0; bus_we_i = 1'b0; bus_be_i = 4'h0;
        bus_addr_i = '0; bus_wdata_i = '0; start_i = 1'b0; tick_i = '0;
        pb_valid_i = 1'b0; pb_addr_i = '0; fifo_rd_i = 1'b0;
        #12;
        check("rst_gnt", bus_gnt_o, 0);
        check("rst_rvalid", bus_rvalid_o, 0);
        check("rst_rdata", bus_rdata_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_pb_ready", pb_ready_o, 0);
        check("rst_fifo_data", fifo_data_o, 0);
        check("rst_fifo_empty", fifo_empty_o, 1);
        check("rst_fifo_count", fifo_count_o, 0);
        @(posedge CLK); #1;
        RSTN = 1'b1;

        for (int w = 0; w < 64; w++) bus_wr(w, 32'h0);

        bus_wr(0, 32'h0403_0201);
        bus_rd("rd_word0", 0, 32'h0403_0201);
        bus_wr(0, 32'h0);

        // Scan with matches on n5, n6, n200 at tick 3.
        bus_wr(1, 32'h0003_0300);
        bus_wr(50, 32'h0000_0003);
        q_idx.push_back(5); q_idx.push_back(6); q_idx.push_back(200);
        pulse_start(8'd3);
        wait_scan(1000, 1'b0, nd);
        check("scan1_done_pulses", nd, 1);
        check("scan1_busy_after", busy_o, 0);
        check("scan1_count", fifo_count_o, 3);
        repeat (3) pop_chk();
        check("scan1_empty", fifo_empty_o, 1);

        // Clear-on-emit zeroed the emitted lanes; a rescan at the same tick emits nothing.
        bus_rd("clr_word1", 1, 32'h0);
        bus_rd("clr_word50", 50, 32'h0);
        pulse_start(8'd3);
        wait_scan(1000, 1'b0, nd);
        check("rescan_done_pulses", nd, 1);
        check("rescan_count", fifo_count_o, 0);

        // Pushback n9 blocked by the bus, then accepted.
        @(posedge CLK); #1;
        tick_i = 8'd7; pb_valid_i = 1'b1; pb_addr_i = 8'd9;
        bus_req_i = 1'b1; bus_we_i = 1'b0; bus_addr_i = 32'h0;
        #1 check("pb_blocked0", pb_ready_o, 0);
        @(posedge CLK); #1;
        check("pb_blocked1", pb_ready_o, 0);
        bus_req_i = 1'b0;
        #1 check("pb_ready", pb_ready_o, 1);
        @(posedge CLK); #1;
        pb_valid_i = 1'b0;
        bus_rd("pb_tick7", 2, 32'h0000_0800);
        @(posedge CLK); #1;
        tick_i = 8'd255; pb_valid_i = 1'b1;
        @(posedge CLK); #1;
        pb_valid_i = 1'b0;
        bus_rd("pb_saturate", 2, 32'h0000_FF00);

        // Scan with bus traffic every other cycle: n9 and n130 at tick 8.
        bus_wr(2, 32'h0000_0800);
        bus_wr(32, 32'h0008_0000);
        q_idx.push_back(9); q_idx.push_back(130);
        pulse_start(8'd8);
        wait_scan(2000, 1'b1, nd);
        check("busy_scan_done_pulses", nd, 1);
        check("busy_scan_count", fifo_count_o, 2);
        repeat (2) pop_chk();

        // Six matches against a four-entry FIFO: scanner stalls until pops.
        bus_wr(10, 32'h1414_1414);
        bus_wr(11, 32'h0000_1414);
        for (int i = 40; i < 46; i++) q_idx.push_back(i);
        pulse_start(8'd20);
        nd = 0;
        for (int c = 0; c < 200; c++) begin
            if (done_o) nd++;
            @(posedge CLK); #1;
        end
        check("stall_count", fifo_count_o, 4);
        check("stall_busy", busy_o, 1);
        check("stall_no_done", nd, 0);
        repeat (2) pop_chk();
        wait_scan(1000, 1'b0, nd);
        check("stall_done_pulses", nd, 1);
        check("stall_final_count", fifo_count_o, 4);
        repeat (4) pop_chk();
        check("stall_empty", fifo_empty_o, 1);

        // Reset mid-scan: n80 emitted, n240 not yet reached.
        bus_wr(20, 32'h0000_0021);
        bus_wr(60, 32'h0000_0021);
        pulse_start(8'h21);
        cyc = 0;
        while (fifo_count_o == 0 && cyc < 600) begin
            @(posedge CLK); #1;
            cyc++;
        end
        check("midscan_emitted", fifo_count_o, 1);
        RSTN = 1'b0;
        #1;
        check("midrst_empty", fifo_empty_o, 1);
        check("midrst_count", fifo_count_o, 0);
        check("midrst_busy", busy_o, 0);
        check("midrst_done", done_o, 0);
        repeat (2) @(posedge CLK);
        #1 RSTN = 1'b1;
        nd = 0;
        for (int c = 0; c < 500; c++) begin
            if (done_o) nd++;
            @(posedge CLK); #1;
        end
        check("midrst_no_done", nd, 0);
        check("midrst_idle", busy_o, 0);
        bus_rd("midrst_sram_kept", 60, 32'h0000_0021);

        check("sb_idx_drained", q_idx.size(), 0);
        check("sb_rd_drained", q_rd.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end
endmodule
